// File: rtl/sram_wb_multibank_ctrl.sv
// Wishbone classic slave in front of NUM_BANKS dual-port SRAM macros: bank decode,
// byte-lane writes by read-modify-write, out-of-range error and registered read data.
module sram_wb_multibank_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          NUM_BANKS  = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter bit          ERR_EN     = 1'b1
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0]         wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic                            wbs_err_o,
  output logic [DATA_WIDTH-1:0]           wbs_dat_o,
  output logic [NUM_BANKS-1:0]            sram_csb0_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr0_o,
  output logic [DATA_WIDTH-1:0]           sram_din0_o,
  output logic [NUM_BANKS-1:0]            sram_csb1_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr1_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout1_i
);

  localparam int SEL_W     = DATA_WIDTH / 8;
  localparam int OFF_BITS  = (SEL_W > 1) ? $clog2(SEL_W) : 0;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int SPAN_BITS = ADDR_WIDTH + BANK_BITS + OFF_BITS;

  typedef enum logic [1:0] {IDLE, RD, RMW, ACK} state_t;

  state_t                  state_reg;
  logic                    ack_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   dat_o_reg;
  logic [DATA_WIDTH-1:0]   dat_reg;
  logic [SEL_W-1:0]        sel_reg;
  logic [ADDR_WIDTH-1:0]   word_reg;
  logic [BANK_W-1:0]       bank_reg;

  logic                    req;
  logic                    in_range;
  logic                    sel_full;
  logic                    sel_none;
  logic [ADDR_WIDTH-1:0]   word_live;
  logic [BANK_W-1:0]       bank_live;
  logic [DATA_WIDTH-1:0]   bank_dout;
  logic [DATA_WIDTH-1:0]   merged;
  logic [NUM_BANKS-1:0]    csb0_next;
  logic [NUM_BANKS-1:0]    csb1_next;
  logic [ADDR_WIDTH-1:0]   addr0_next;
  logic [DATA_WIDTH-1:0]   din0_next;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign in_range  = (wbs_adr_i >> SPAN_BITS) == (BASE_ADDR >> SPAN_BITS);
  assign sel_full  = &wbs_sel_i;
  assign sel_none  = ~|wbs_sel_i;
  assign word_live = wbs_adr_i[OFF_BITS +: ADDR_WIDTH];

  generate
    if (BANK_BITS > 0) begin : g_bank_decode
      assign bank_live = wbs_adr_i[ADDR_WIDTH+OFF_BITS +: BANK_W];
    end else begin : g_single_bank
      assign bank_live = '0;
    end
  endgenerate

  assign bank_dout = sram_dout1_i[bank_reg*DATA_WIDTH +: DATA_WIDTH];

  // Unselected lanes keep whatever the macro returned for the old word.
  generate
    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_lane_merge
      assign merged[gi*8 +: 8] = sel_reg[gi] ? dat_reg[gi*8 +: 8] : bank_dout[gi*8 +: 8];
    end
  endgenerate

  // Chip selects follow the live request in IDLE and the latched request in RMW.
  always_comb begin
    csb0_next  = '1;
    csb1_next  = '1;
    addr0_next = word_live;
    din0_next  = wbs_dat_i;
    if (!wb_rst_i) begin
      case (state_reg)
        IDLE: begin
          if (req && in_range) begin
            if (wbs_we_i && sel_full) begin
              csb0_next[bank_live] = 1'b0;
            end else if (!wbs_we_i || !sel_none) begin
              csb1_next[bank_live] = 1'b0;
            end
          end
        end
        RMW: begin
          addr0_next = word_reg;
          din0_next  = merged;
          if (wbs_cyc_i) begin
            csb0_next[bank_reg] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_o_reg <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      word_reg  <= '0;
      bank_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            word_reg <= word_live;
            bank_reg <= bank_live;
            dat_reg  <= wbs_dat_i;
            sel_reg  <= wbs_sel_i;
            if (!in_range) begin
              dat_o_reg <= '0;
              ack_reg   <= ~ERR_EN;
              err_reg   <= ERR_EN;
              state_reg <= ACK;
            end else if (!wbs_we_i) begin
              state_reg <= RD;
            end else if (sel_full || sel_none) begin
              ack_reg   <= 1'b1;
              state_reg <= ACK;
            end else begin
              state_reg <= RMW;
            end
          end
        end
        RD: begin
          if (!wbs_cyc_i) begin
            state_reg <= IDLE;
          end else begin
            dat_o_reg <= bank_dout;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end
        end
        RMW: begin
          if (!wbs_cyc_i) begin
            state_reg <= IDLE;
          end else begin
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o    = ack_reg;
  assign wbs_err_o    = err_reg;
  assign wbs_dat_o    = dat_o_reg;
  assign sram_csb0_o  = csb0_next;
  assign sram_addr0_o = addr0_next;
  assign sram_din0_o  = din0_next;
  assign sram_csb1_o  = csb1_next;
  assign sram_addr1_o = word_live;

endmodule

// File: tb/tb_sram_wb_multibank_ctrl.sv
// Bench: transaction-level memory model plus per-cycle compare of ack/err/dat_o,
// with behavioural SRAM macros attached and an ERR_EN=0 twin sharing the inputs.
module tb_sram_wb_multibank_ctrl;

  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] WIN_BYTES = 32'h0000_2000;

  logic        clk;
  logic        rst;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;

  logic        ack0, err0, ack1, err1;
  logic [31:0] dato0, dato1;
  logic [1:0]  csb0, csb1, csb0_b, csb1_b;
  logic [9:0]  addr0, addr1, addr0_b, addr1_b;
  logic [31:0] din0, din0_b;
  logic [63:0] sram_dout;

  sram_wb_multibank_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb_i), .wbs_cyc_i(cyc_i), .wbs_we_i(we_i),
    .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack0), .wbs_err_o(err0), .wbs_dat_o(dato0),
    .sram_csb0_o(csb0), .sram_addr0_o(addr0), .sram_din0_o(din0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(sram_dout)
  );

  sram_wb_multibank_ctrl #(.ERR_EN(1'b0)) dut_noerr (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb_i), .wbs_cyc_i(cyc_i), .wbs_we_i(we_i),
    .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack1), .wbs_err_o(err1), .wbs_dat_o(dato1),
    .sram_csb0_o(csb0_b), .sram_addr0_o(addr0_b), .sram_din0_o(din0_b),
    .sram_csb1_o(csb1_b), .sram_addr1_o(addr1_b), .sram_dout1_i(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macros: write on edge when csb0 low, read registered when csb1 low.
  logic [31:0] sram_mem [2][1024];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!csb0[b]) sram_mem[b][addr0] <= din0;
      if (!csb1[b]) sram_dout[b*32 +: 32] <= sram_mem[b][addr1];
    end
  end

  int tot_w [2];
  int tot_r [2];
  int last_waddr, last_raddr;
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!csb0[b]) begin tot_w[b] = tot_w[b] + 1; last_waddr = int'(addr0); end
      if (!csb1[b]) begin tot_r[b] = tot_r[b] + 1; last_raddr = int'(addr1); end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: word-indexed memory over the whole window and expected outputs.
  logic [31:0] mdl_mem [2048];
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dat = 32'h0;
  int          cyc_n = 0;
  int          last_ack = -1;

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    chk("ack", {31'h0, ack0}, {31'h0, exp_ack});
    chk("err", {31'h0, err0}, {31'h0, exp_err});
    chk("dat_o", dato0, exp_dat);
    chk("ack_noerr_inst", {31'h0, ack1}, {31'h0, exp_ack | exp_err});
    chk("err_noerr_inst", {31'h0, err1}, 32'h0);
    chk("csb_single", {31'h0, ($countones(~csb0) + $countones(~csb1)) <= 1}, 32'h1);
    if (ack0 || err0) begin
      if (last_ack >= 0) chk("ack_gap", {31'h0, (cyc_n - last_ack) >= 2}, 32'h1);
      last_ack = cyc_n;
    end
  end

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit abort, input bit hold);
    bit          in_rng, is_err, upd_dat, upd_mem, do_abort;
    int          idx, lat;
    logic [31:0] new_dat, merged;
    in_rng  = (adr >= BASE) && (adr < BASE + WIN_BYTES);
    idx     = in_rng ? int'((adr - BASE) >> 2) : 0;
    lat     = 1;
    is_err  = 1'b0;
    upd_dat = 1'b0;
    upd_mem = 1'b0;
    new_dat = exp_dat;
    merged  = 32'h0;
    if (!in_rng) begin
      is_err  = 1'b1;
      upd_dat = 1'b1;
      new_dat = 32'h0;
    end else if (!we) begin
      lat     = 2;
      upd_dat = 1'b1;
      new_dat = mdl_mem[idx];
    end else if (sel != 4'h0) begin
      merged = mdl_mem[idx];
      for (int i = 0; i < 4; i++) if (sel[i]) merged[i*8 +: 8] = dat[i*8 +: 8];
      upd_mem = 1'b1;
      if (sel != 4'hF) lat = 2;
    end
    do_abort = abort && (lat == 2);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    exp_ack = 1'b0; exp_err = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (do_abort) begin
        cyc_i = 1'b0; stb_i = 1'b0;
        break;
      end
      if (k == lat) begin
        exp_ack = ~is_err;
        exp_err = is_err;
        if (upd_dat) exp_dat = new_dat;
        if (upd_mem) mdl_mem[idx] = merged;
      end
    end
    @(posedge clk); #1;
    exp_ack = 1'b0; exp_err = 1'b0;
    if (!hold) begin cyc_i = 1'b0; stb_i = 1'b0; end
    $display("xfer we=%0d adr=%h dat=%h sel=%h lat=%0d abort=%0d hold=%0d exp_dat_o=%h",
             we, adr, dat, sel, lat, do_abort, hold, exp_dat);
  endtask

  int sw [2];
  int sr [2];
  task automatic snap();
    for (int b = 0; b < 2; b++) begin sw[b] = tot_w[b]; sr[b] = tot_r[b]; end
  endtask

  initial begin
    logic [31:0] radr, rdat;
    logic [3:0]  rsel;
    int          rk, rs;
    bit          rwe, rab, rhold;

    rst = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; adr_i = 32'h0; dat_i = 32'h0;
    for (int b = 0; b < 2; b++) begin tot_w[b] = 0; tot_r[b] = 0; end
    last_waddr = -1; last_raddr = -1;
    repeat (2) @(posedge clk);
    #1;
    // A live request during reset must not pull any chip select low.
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = BASE + 32'h4; sel_i = 4'hF;
    #1;
    chk("rst_csb0", {30'h0, csb0}, 32'h3);
    chk("rst_csb1", {30'h0, csb1}, 32'h3);
    chk("rst_ack", {31'h0, ack0}, 32'h0);
    chk("rst_dat_o", dato0, 32'h0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the words the test touches so model and macros agree.
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 8; w++)
        xfer(1'b1, BASE + 32'(b*4096 + w*4), $urandom, 4'hF, 1'b0, 1'b0);

    // Full write and readback at bank 0 word 1.
    snap();
    xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    chk("wr0_bank0_writes", 32'(tot_w[0] - sw[0]), 32'h1);
    chk("wr0_bank1_writes", 32'(tot_w[1] - sw[1]), 32'h0);
    chk("wr0_word", 32'(last_waddr), 32'h1);
    snap();
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("rd0_bank0_reads", 32'(tot_r[0] - sr[0]), 32'h1);
    chk("rd0_word", 32'(last_raddr), 32'h1);
    chk("rd0_data", dato0, 32'hDEAD_BEEF);

    // Partial write via RMW on bank 1 word 0.
    xfer(1'b1, 32'h3000_1000, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    snap();
    xfer(1'b1, 32'h3000_1000, 32'hAAAA_AAAA, 4'b0101, 1'b0, 1'b0);
    chk("rmw_bank1_reads", 32'(tot_r[1] - sr[1]), 32'h1);
    chk("rmw_bank1_writes", 32'(tot_w[1] - sw[1]), 32'h1);
    chk("rmw_bank0_untouched", 32'(tot_w[0] - sw[0] + tot_r[0] - sr[0]), 32'h0);
    chk("rmw_word", 32'(last_waddr), 32'h0);
    xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("rmw_readback", dato0, 32'h11AA_33AA);

    // Out of range: err on the main instance, ack on the twin, no macro access.
    snap();
    xfer(1'b0, 32'h3000_2000, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("oob_dat_o", dato0, 32'h0);
    chk("oob_no_access", 32'(tot_w[0] - sw[0] + tot_w[1] - sw[1] + tot_r[0] - sr[0] + tot_r[1] - sr[1]), 32'h0);

    // sel=0 write: acked, no access, data untouched.
    snap();
    xfer(1'b1, 32'h3000_0004, 32'h1234_5678, 4'h0, 1'b0, 1'b0);
    chk("sel0_no_access", 32'(tot_w[0] - sw[0] + tot_w[1] - sw[1] + tot_r[0] - sr[0] + tot_r[1] - sr[1]), 32'h0);
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("sel0_readback", dato0, 32'hDEAD_BEEF);

    // Abort during RMW: no write, then a normal read.
    snap();
    xfer(1'b1, 32'h3000_1000, 32'h5555_5555, 4'b0011, 1'b1, 1'b0);
    chk("abort_no_write", 32'(tot_w[0] - sw[0] + tot_w[1] - sw[1]), 32'h0);
    xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("abort_readback", dato0, 32'h11AA_33AA);

    // Reset in the middle of a read.
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0004; sel_i = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_dat = 32'h0;
    #1;
    chk("rstrd_ack", {31'h0, ack0}, 32'h0);
    chk("rstrd_err", {31'h0, err0}, 32'h0);
    chk("rstrd_dat_o", dato0, 32'h0);
    chk("rstrd_csb", {28'h0, csb0, csb1}, 32'hF);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("rstrd_readback", dato0, 32'hDEAD_BEEF);

    // Strobe held across two transfers.
    xfer(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("b2b_readback", dato0, 32'hCAFE_F00D);

    // Randomized traffic over a small set of words, with some out-of-range hits.
    for (int n = 0; n < 150; n++) begin
      rk = int'($urandom_range(0, 9));
      rs = int'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      rdat = $urandom;
      if (rk == 0) radr = BASE + WIN_BYTES + ($urandom_range(0, 255) << 2);
      else if (rk == 1) radr = $urandom;
      else radr = BASE + ($urandom_range(0, 1) << 12) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (rs == 0) rsel = 4'hF;
      else if (rs == 1) rsel = 4'h0;
      else rsel = 4'($urandom_range(0, 15));
      rab = ($urandom_range(0, 7) == 0);
      rhold = ($urandom_range(0, 3) == 0) && !rab;
      xfer(rwe, radr, rdat, rsel, rab, rhold);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_wb_multibank_ctrl.md
# sram_wb_multibank_ctrl

Wishbone classic slave that maps a contiguous address window onto `NUM_BANKS` dual-port OpenRAM-style SRAM macros (one write port, one read port, active-low chip selects). It adds byte-lane writes by read-modify-write, multi-bank address decode, out-of-range detection with an optional bus error, and registered read data. It sits between the Caravel user-area Wishbone bus and the SRAM macro instances, which are instantiated outside this block and clocked by `wb_clk_i`.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8; `SEL_W = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 10: word-address width of each macro.
- `NUM_BANKS`, 2: number of macros; a power of two ≥1. `BANK_BITS = clog2(NUM_BANKS)`, 0 when 1.
- `BASE_ADDR`, 32'h3000_0000: window base; aligned to `SPAN_BITS = ADDR_WIDTH + BANK_BITS + clog2(SEL_W)`.
- `ERR_EN`, 1: 1 = out-of-range ends with `wbs_err_o`; 0 = ends with `wbs_ack_o`.
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle, write enable.
- `wbs_sel_i`  in  SEL_W  byte-lane select.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  DATA_WIDTH  write data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_err_o`  out  1  error acknowledge.
- `wbs_dat_o`  out  DATA_WIDTH  registered read data.
- `sram_csb0_o`  out  NUM_BANKS  per-bank write chip select, active low.
- `sram_addr0_o`  out  ADDR_WIDTH  write address, shared by all banks.
- `sram_din0_o`  out  DATA_WIDTH  write data, shared by all banks.
- `sram_csb1_o`  out  NUM_BANKS  per-bank read chip select, active low.
- `sram_addr1_o`  out  ADDR_WIDTH  read address, shared by all banks.
- `sram_dout1_i`  in  NUM_BANKS*DATA_WIDTH  read data; bank b occupies bits `[b*DATA_WIDTH +: DATA_WIDTH]`.

## Operation
- Request: `req = wbs_cyc_i & wbs_stb_i`, sampled in IDLE. On acceptance, adr, dat, sel and we are latched. All later states drive the SRAM from the latched copies.
- Decode: in range iff `adr[31:SPAN_BITS] == BASE_ADDR[31:SPAN_BITS]`.
  - word = `adr[SPAN_BITS-BANK_BITS-1 : clog2(SEL_W)]`
  - bank = `adr[SPAN_BITS-1 : SPAN_BITS-BANK_BITS]`
  - The low byte-offset bits are ignored.
- Only the selected bank's csb goes low. All csb are high in IDLE (except as listed under the IDLE transitions below), in ACK, and during reset. The csb and addr outputs are combinational from the state and the request/latched request.
- FSM states: IDLE, RD, RMW, ACK.
  - IDLE, read in range: `csb1[bank]=0`, `addr1` = word from live inputs → RD.
  - IDLE, write with sel all ones: `csb0[bank]=0`, `din0 = wbs_dat_i` → ACK; set ack.
  - IDLE, write with partial sel (nonzero): issue read as for a read → RMW.
  - IDLE, write with sel=0: no SRAM access → ACK; set ack.
  - IDLE, out of range: no SRAM access; `wbs_dat_o <= 0` → ACK; set err if `ERR_EN` else ack.
  - RD: capture the bank's dout into `wbs_dat_o`; set ack → ACK.
  - RMW: merged word = for each lane i, `sel[i] ? dat[i] : dout[i]`. Drive `csb0[bank]=0` with the merged word; set ack → ACK.
  - ACK: ack/err high for exactly this cycle → IDLE. The mandatory idle cycle means no back-to-back acks.
- Abort: if `wbs_cyc_i` is low in RD or RMW:
  - no SRAM write occurs;
  - no ack/err is raised;
  - the FSM goes straight to IDLE.
- `wbs_dat_o` holds its last value between reads. Write transfers do not change it.

## Timing
- Reset values: `wbs_ack_o=0`, `wbs_err_o=0`, `wbs_dat_o=0`, state IDLE, all csb high. A reset mid-RMW cancels the pending write.
- Latency, counted in cycles from the request cycle (C0) to the ack cycle:
  - full write, sel=0 write, out-of-range: 1 (ack in C1);
  - read and partial write: 2 (ack in C2).
- Macro read: csb1 is sampled at edge N; dout is valid during cycle N+1.
- The master must hold stb until ack/err (Wishbone classic). A new request is accepted only in IDLE.
- Ack and err are never high together.

## Test plan
- Write 32'hDEADBEEF with sel=F to 0x3000_0004, then read it back → ack in C1 on the write; the read acks in C2 with data DEADBEEF; bank 0 word 1 is accessed.
- Write 0x1122_3344 to 0x3000_1000 (bank 1 word 0), then write 0xAAAA_AAAA with sel=4'b0101 → the RMW read and write hit bank 1 only; a readback returns 0x11AA_33AA; ack for the partial write in C2.
- Access 0x3000_2000 (out of range) with `ERR_EN=1` → err in C1, dat_o=0, all csb stay high. Repeat with `ERR_EN=0` → ack instead of err.
- Write with sel=0 → ack in C1, no csb low; a later readback shows the data unchanged.
- Drop cyc during RMW → no csb0 pulse, no ack, FSM back in IDLE; a following read acks normally.
- Assert reset during RD → ack, err and dat_o return to 0 immediately and all csb go high; a read after reset succeeds. Separately, hold stb continuously across two transfers → the acks are separated by at least one idle cycle.
